// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic engines.
// Holds the FSM state encoding and a constant-function counter-width helper.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to hold values 0..n-1; never less than one.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/serial_adder_fsm_full_adder_bit.sv
// One-bit full adder, purely combinational.
// Ports: a, b, cin (inputs); s = a^b^cin, cout = majority(a, b, cin).
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_fsm.sv
// Bit-serial WIDTH-bit adder: one full adder plus a carry flop, LSB first.
// Ports: clk, rst_n, start, a, b in; busy, done, sum, carry_out out (all registered).
module serial_adder_fsm #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    import serial_arith_pkg::*;

    localparam int CW = clog2(WIDTH + 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;
    logic             c;

    logic             fa_s;
    logic             fa_cout;
    logic [WIDTH-1:0] acc_next;
    logic             last_bit;

    full_adder_bit u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (c),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
    generate
        if (WIDTH == 1) begin : g_one
            assign acc_next = fa_s;
        end else begin : g_many
            assign acc_next = {fa_s, acc[WIDTH-1:1]};
        end
    endgenerate

    assign last_bit = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            acc       <= '0;
            cnt       <= '0;
            c         <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        a_sh  <= a;
                        b_sh  <= b;
                        acc   <= '0;
                        cnt   <= '0;
                        c     <= 1'b0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    c    <= fa_cout;
                    acc  <= acc_next;
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    cnt  <= cnt + CW'(1);
                    if (last_bit) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        sum       <= acc_next;
                        carry_out <= fa_cout;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
